// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard path: receive states and scan-code constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Prefix bytes
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_EXT1  = 8'hE1;

  // Make codes with special handling
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

endpackage

// File: rtl/ps2_kb_decoder_if.sv
// Keyboard decoder port bundle: raw PS/2 lines in, decoded key stream out.
interface ps2_kb_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic [7:0] ascii_code;
  logic       kb_valid;
  logic       shift_on;
  logic       caps_on;
  logic       frame_err;

  // Decoder side
  modport master (
    input  ps2_clk, ps2_data,
    output scan_code, ascii_code, kb_valid, shift_on, caps_on, frame_err
  );

  // Keyboard / downstream side
  modport slave (
    output ps2_clk, ps2_data,
    input  scan_code, ascii_code, kb_valid, shift_on, caps_on, frame_err
  );
endinterface

// File: rtl/scan_to_ascii.sv
// Combinational scan-code set 2 to ASCII table. Returns 0 for unmapped codes.
module scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       is_letter;

  // Look up the unshifted/shifted glyph pair; letters derive their upper case.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips an assignment infers a latch.
    lo        = 8'h00;
    hi        = 8'h00;
    is_letter = 1'b0;
    case (scan)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h16: {lo, hi} = {"1", "!"};   8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};   8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};   8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};   8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};   8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"}; 8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};   8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};   8'h5D: {lo, hi} = {"\\", "|"};
      8'h4C: {lo, hi} = {";", ":"};   8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};   8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      SC_ENTER: {lo, hi} = {8'h0D, 8'h0D};
      SC_BKSP:  {lo, hi} = {8'h08, 8'h08};
      8'h29:    {lo, hi} = {8'h20, 8'h20};
      8'h0D:    {lo, hi} = {8'h09, 8'h09};
      default:  {lo, hi} = {8'h00, 8'h00};
    endcase
    is_letter = (lo >= "a") && (lo <= "z");
    if (is_letter) hi = lo - 8'h20;
    ascii = is_letter ? ((shift ^ caps) ? hi : lo) : (shift ? hi : lo);
  end

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes bytes, tracks
// break/extended prefixes and modifiers, and strobes one ASCII character per keystroke.
module ps2_kb_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_kb_decoder_if.master kb
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  // Synchronizers
  logic ps2_clk_meta_q, ps2_clk_meta_d, ps2_clk_sync_q, ps2_clk_sync_d;
  logic ps2_clk_prev_q, ps2_clk_prev_d;
  logic ps2_data_meta_q, ps2_data_meta_d, ps2_data_sync_q, ps2_data_sync_d;
  logic fall_edge, data_bit;

  // Receiver
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  // Decode state and outputs
  logic       brk_q, brk_d, ext_q, ext_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       caps_q, caps_d, caps_held_q, caps_held_d;
  logic [7:0] scan_code_q, scan_code_d, ascii_code_q, ascii_code_d;
  logic       kb_valid_q, kb_valid_d;
  logic [7:0] lookup_ascii;

  // Two-stage synchronizers plus a delayed clock copy for falling-edge detection.
  always_comb begin
    ps2_clk_meta_d  = kb.ps2_clk;
    ps2_clk_sync_d  = ps2_clk_meta_q;
    ps2_clk_prev_d  = ps2_clk_sync_q;
    ps2_data_meta_d = kb.ps2_data;
    ps2_data_sync_d = ps2_data_meta_q;
    fall_edge       = ps2_clk_prev_q & ~ps2_clk_sync_q;
    data_bit        = ps2_data_sync_q;
  end

  // Receive FSM next state, frame checks and the saturating inactivity timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_byte_d    = rx_byte_q;
    parity_d     = parity_q;
    tmo_cnt_d    = tmo_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == RX_IDLE || fall_edge) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_q == TMO_MAX - TMO_W'(1)) begin
        frame_err_d = 1'b1;
        state_d     = RX_IDLE;
      end
    end

    if (fall_edge) begin
      case (state_q)
        RX_IDLE: begin
          // A high start bit is line noise and is ignored silently.
          if (!data_bit) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          rx_byte_d = {data_bit, rx_byte_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = data_bit;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (data_bit && (^{rx_byte_q, parity_q})) frame_done_d = 1'b1;
          else                                      frame_err_d  = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  scan_to_ascii u_scan_to_ascii (
    .scan  (rx_byte_q),
    .shift (lshift_q | rshift_q),
    .caps  (caps_q),
    .ascii (lookup_ascii)
  );

  // Byte decode: prefix flags, modifier tracking and the character strobe.
  always_comb begin
    brk_d        = brk_q;
    ext_d        = ext_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    caps_d       = caps_q;
    caps_held_d  = caps_held_q;
    scan_code_d  = scan_code_q;
    ascii_code_d = ascii_code_q;
    kb_valid_d   = 1'b0;

    if (frame_err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (frame_done_q) begin
      if (rx_byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte_q == PS2_EXT || rx_byte_q == PS2_EXT1) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          case (rx_byte_q)
            SC_LSHIFT: lshift_d = !brk_q;
            SC_RSHIFT: rshift_d = !brk_q;
            SC_CAPS: begin
              // Typematic repeats of Caps must not toggle again until released.
              if (brk_q) begin
                caps_held_d = 1'b0;
              end else begin
                if (!caps_held_q) caps_d = !caps_q;
                caps_held_d = 1'b1;
              end
            end
            default: begin
              if (!brk_q && lookup_ascii != 8'h00) begin
                scan_code_d  = rx_byte_q;
                ascii_code_d = lookup_ascii;
                kb_valid_d   = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // State registers with synchronous reset; synchronizers idle high like the bus.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
      state_q         <= RX_IDLE;
      bit_cnt_q       <= 3'd0;
      rx_byte_q       <= 8'h00;
      parity_q        <= 1'b0;
      tmo_cnt_q       <= '0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      brk_q           <= 1'b0;
      ext_q           <= 1'b0;
      lshift_q        <= 1'b0;
      rshift_q        <= 1'b0;
      caps_q          <= 1'b0;
      caps_held_q     <= 1'b0;
      scan_code_q     <= 8'h00;
      ascii_code_q    <= 8'h00;
      kb_valid_q      <= 1'b0;
    end else begin
      ps2_clk_meta_q  <= ps2_clk_meta_d;
      ps2_clk_sync_q  <= ps2_clk_sync_d;
      ps2_clk_prev_q  <= ps2_clk_prev_d;
      ps2_data_meta_q <= ps2_data_meta_d;
      ps2_data_sync_q <= ps2_data_sync_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_byte_q       <= rx_byte_d;
      parity_q        <= parity_d;
      tmo_cnt_q       <= tmo_cnt_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      brk_q           <= brk_d;
      ext_q           <= ext_d;
      lshift_q        <= lshift_d;
      rshift_q        <= rshift_d;
      caps_q          <= caps_d;
      caps_held_q     <= caps_held_d;
      scan_code_q     <= scan_code_d;
      ascii_code_q    <= ascii_code_d;
      kb_valid_q      <= kb_valid_d;
    end
  end

  assign kb.scan_code  = scan_code_q;
  assign kb.ascii_code = ascii_code_q;
  assign kb.kb_valid   = kb_valid_q;
  assign kb.shift_on   = lshift_q | rshift_q;
  assign kb.caps_on    = caps_q;
  assign kb.frame_err  = frame_err_q;

endmodule

// File: doc/ps2_kb_decoder.md
# ps2_kb_decoder

Upstream stage of the keyboard-to-text-display path. Receives raw PS/2 keyboard frames, validates them, tracks prefix/modifier state and converts make codes to ASCII. Emits a single-cycle `kb_valid` strobe with `scan_code`/`ascii_code` to the cursor controller and character-write logic. One strobe corresponds to one printable keystroke, so downstream advances the cursor exactly once per character, typematic repeats included.

## Interface
- `TIMEOUT_CYCLES`, 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `scan_code`  out  8  make code of last accepted key; held between strobes.
- `ascii_code`  out  8  ASCII of last accepted key; held between strobes.
- `kb_valid`  out  1  one-cycle strobe: new `scan_code`/`ascii_code` valid.
- `shift_on`  out  1  either Shift (0x12 / 0x59) currently held.
- `caps_on`  out  1  Caps Lock toggle state.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A falling edge is synchronized `ps2_clk` going 1 in the previous cycle to 0 in the current cycle. Data is sampled in the edge cycle.
- **Receive FSM:**
  - IDLE: on edge, if data = 0 go to DATA with bit count 0. A start bit of 1 is a glitch: stay in IDLE, no error.
  - DATA: shift 8 bits LSB first. After bit 7 go to PARITY.
  - PARITY: latch bit and go to STOP.
  - STOP: on edge, if stop bit = 1 and odd parity holds, pulse internal `frame_done` with the byte. Otherwise pulse `frame_err`. Always return to IDLE.
- **Timeout:** in any state other than IDLE, a counter reaches `TIMEOUT_CYCLES` with no edge. Response: `frame_err` pulse, return to IDLE, clear prefix flags.
- **Decode on `frame_done`:**
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - 0xE1 sets `ext`; the Pause sequence is ignored.
  - Any other byte is a key code and clears `brk` and `ext` after use.
- **Modifier handling:**
  - Shift make/break sets/clears the per-side held bit. `shift_on` is the OR of both sides.
  - Caps (0x58) toggles `caps_on` on make only when `caps_held`=0. `caps_held` is set on make and cleared on break, so auto-repeat does not toggle again.
  - Extended codes (`ext`=1) never change modifiers and never strobe.
- **Strobe:** a non-extended, non-break, non-modifier key whose lookup ASCII is non-zero updates `scan_code`/`ascii_code` and pulses `kb_valid`. Codes with ASCII 0 are dropped silently.
- **ASCII lookup:**
  - Letters: uppercase when `shift_on` XOR `caps_on`.
  - Digits and punctuation: shifted glyph when `shift_on` only.
  - Fixed codes: Enter 0x5A→0x0D, Backspace 0x66→0x08, Space 0x29→0x20, Tab 0x0D→0x09.
- **Errors:** any `frame_err` clears `brk` and `ext`. Modifier state is kept.

## Timing
- **Reset values:** `scan_code`=0, `ascii_code`=0, `kb_valid`=0, `shift_on`=0, `caps_on`=0, `frame_err`=0. FSM in IDLE, all flags and counters cleared. A reset mid-frame discards the partial byte.
- **Strobe latency:** stop-bit edge detected in cycle N. `frame_done` is in cycle N+1. `kb_valid`, `scan_code` and `ascii_code` are registered in cycle N+2. `kb_valid` is high exactly one cycle.
- **Modifier latency:** modifier outputs update in cycle N+2 and apply to the next key frame.
- **Error latency:** `frame_err` is high in cycle N+1 for parity/stop errors, and in the cycle the timeout counter expires.
- **Back-to-back frames:** the minimum PS/2 gap (≥ 1 bit period) exceeds 2 cycles, so no output buffering is needed.
- **Wrap:** the timeout counter saturates and does not wrap.

## Structure
- **Shared package `ps2_pkg`:**
  - Receive-state enum.
  - Constants `PS2_BRK`=0xF0, `PS2_EXT`=0xE0, `PS2_EXT1`=0xE1.
  - Constants `SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59, `SC_CAPS`=0x58, `SC_ENTER`=0x5A, `SC_BKSP`=0x66.
- **Sub-module `scan_to_ascii`:** purely combinational table with inputs scan code, shift and caps, and output ASCII (0 = unmapped). It is reusable by a later display block.
- **Top level:** synchronizers, receive FSM, timeout counter, decode flags and output registers.

## Test plan
- Frame 0x1C (A), correct parity, 40-cycle half bit period. Required: `kb_valid` for 1 cycle, 2 cycles after the stop edge, with `scan_code`=0x1C and `ascii_code`=0x61.
- Sequence 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12. Required: `shift_on` 1 then 0, one strobe with `ascii_code`=0x41, no strobe on either break.
- 0x58 make three times (repeat), then 0xF0 0x58, then 0x15. Required: `caps_on`=1 after the first make only, and `ascii_code`=0x51 for 0x15.
- Frame 0x1C with wrong parity, then a 0x1C frame with stop=0. Required: two `frame_err` pulses, no `kb_valid`, outputs unchanged.
- Abort after 4 data bits, wait `TIMEOUT_CYCLES`+5, then a valid 0x29 frame. Required: one `frame_err`, then a strobe with `ascii_code`=0x20.
- E0 0x75 (up arrow), E0 F0 0x75, `rst` asserted mid-frame, then 0x5A. Required: no strobe for the arrow, all outputs 0 after reset, strobe with `ascii_code`=0x0D.
